// File: rtl/sca_blk_sched_pkg.sv
// Shared types and constants for the SCA capture-block scheduler.
package sca_pkg;
  localparam int NBLK  = 16;
  localparam int AW    = 4;
  localparam int L1AW  = 8;
  localparam int MISSW = 8;

  typedef enum logic [1:0] {ST_FREE, ST_ALLOC, ST_QUEUED} blk_st_e;

  typedef struct packed {
    logic [AW-1:0]   adr;
    logic [L1AW-1:0] l1abin;
  } q_ent_t;
endpackage

// File: rtl/sca_blk_sched_if.sv
// Bus between the LCT/readout side and the SCA block scheduler.
interface sca_blk_sched_if;
  import sca_pkg::*;

  logic            ALLOC_REQ;
  logic            ALLOC_ACK;
  logic [AW-1:0]   ALLOC_ADR;
  logic            SCAFULL;
  logic [AW:0]     NFREE;
  logic            CONF_VLD;
  logic            CONF_DROP;
  logic [AW-1:0]   CONF_ADR;
  logic [L1AW-1:0] CONF_L1ABIN;
  logic            RD_POP;
  logic            GTRGEMPTY;
  logic [AW-1:0]   RADR;
  logic [L1AW-1:0] L1ABIN;
  logic            RLS_VLD;
  logic [AW-1:0]   RLS_ADR;
  logic [MISSW-1:0] MISSCNT;
  logic            ERR;

  modport slave (
    input  ALLOC_REQ, CONF_VLD, CONF_DROP, CONF_ADR, CONF_L1ABIN, RD_POP, RLS_VLD, RLS_ADR,
    output ALLOC_ACK, ALLOC_ADR, SCAFULL, NFREE, GTRGEMPTY, RADR, L1ABIN, MISSCNT, ERR
  );

  modport master (
    output ALLOC_REQ, CONF_VLD, CONF_DROP, CONF_ADR, CONF_L1ABIN, RD_POP, RLS_VLD, RLS_ADR,
    input  ALLOC_ACK, ALLOC_ADR, SCAFULL, NFREE, GTRGEMPTY, RADR, L1ABIN, MISSCNT, ERR
  );
endinterface

// File: rtl/sca_blk_sched_rdq.sv
// First-word-fall-through readout queue of confirmed blocks.
module sca_rdq
  import sca_pkg::*;
#(
  parameter int DEPTH = NBLK
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   i_push,
  input  q_ent_t i_din,
  input  logic   i_pop,
  output q_ent_t o_head,
  output logic   o_empty,
  output logic   o_full,
  output logic   o_ovf,
  output logic   o_unf
);
  localparam int PW = $clog2(DEPTH);

  q_ent_t        r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          w_pop, w_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  // A pop on a full queue frees the slot the simultaneous push needs.
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_unf   = i_pop && o_empty;
  assign o_ovf   = i_push && o_full && !w_pop;
  assign o_head  = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= ptr_inc(r_wp);
      if (w_pop)  r_rp <= ptr_inc(r_rp);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/sca_blk_sched.sv
// SCA capture-block pool: allocation, confirm/drop, readout queue and release.
module sca_blk_sched
  import sca_pkg::*;
(
  input logic CLK,
  input logic RST,
  sca_blk_sched_if.slave bus
);
  localparam int NW = AW + 1;

  blk_st_e          r_st     [NBLK];
  blk_st_e          w_st_nxt [NBLK];
  logic [NBLK-1:0]  w_free;
  logic             w_any_free;
  logic [AW-1:0]    w_gnt_idx;
  logic             w_gnt, w_miss;
  logic             w_conf_ok, w_conf_err, w_drop_ok, w_push_req, w_push_acc;
  logic             w_rls_ok, w_rls_err;
  logic             w_pop_eff, w_empty, w_full, w_ovf, w_unf;
  q_ent_t           w_din, w_head;
  logic [NW-1:0]    r_nfree, w_nfree_nxt;
  logic             r_full, r_ack, r_err;
  logic [AW-1:0]    r_adr;
  logic [MISSW-1:0] r_miss;

  // Everything below decides from the pre-cycle block states.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NBLK; i++) w_free[i] = (r_st[i] == ST_FREE);
    for (int i = NBLK-1; i >= 0; i--)
      if (w_free[i]) w_gnt_idx = AW'(i);
  end

  assign w_any_free = |w_free;
  assign w_gnt      = bus.ALLOC_REQ && w_any_free;
  assign w_miss     = bus.ALLOC_REQ && !w_any_free;

  assign w_conf_ok  = bus.CONF_VLD && (r_st[bus.CONF_ADR] == ST_ALLOC);
  assign w_conf_err = bus.CONF_VLD && !w_conf_ok;
  assign w_drop_ok  = w_conf_ok && bus.CONF_DROP;
  assign w_push_req = w_conf_ok && !bus.CONF_DROP;
  assign w_pop_eff  = bus.RD_POP && !w_empty;
  assign w_push_acc = w_push_req && (!w_full || w_pop_eff);

  assign w_rls_ok   = bus.RLS_VLD && (r_st[bus.RLS_ADR] == ST_QUEUED);
  assign w_rls_err  = bus.RLS_VLD && !w_rls_ok;

  assign w_din = '{adr: bus.CONF_ADR, l1abin: bus.CONF_L1ABIN};

  // Grant/confirm/release need distinct pre-states, so they never hit the same block.
  always_comb begin
    for (int i = 0; i < NBLK; i++) w_st_nxt[i] = r_st[i];
    if (w_gnt)      w_st_nxt[w_gnt_idx]    = ST_ALLOC;
    if (w_drop_ok)  w_st_nxt[bus.CONF_ADR] = ST_FREE;
    if (w_push_acc) w_st_nxt[bus.CONF_ADR] = ST_QUEUED;
    if (w_rls_ok)   w_st_nxt[bus.RLS_ADR]  = ST_FREE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NBLK; i++) r_st[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < NBLK; i++) r_st[i] <= w_st_nxt[i];
    end
  end

  assign w_nfree_nxt = r_nfree - NW'(w_gnt) + NW'(w_drop_ok) + NW'(w_rls_ok);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_nfree <= NW'(NBLK);
      r_full  <= 1'b0;
      r_ack   <= 1'b0;
      r_adr   <= '0;
      r_miss  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_nfree <= w_nfree_nxt;
      r_full  <= (w_nfree_nxt == '0);
      r_ack   <= w_gnt;
      if (w_gnt) r_adr <= w_gnt_idx;
      if (w_miss && (r_miss != '1)) r_miss <= r_miss + MISSW'(1);
      if (w_conf_err || w_rls_err || w_ovf || w_unf) r_err <= 1'b1;
    end
  end

  sca_rdq #(.DEPTH(NBLK)) u_rdq (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push_req),
    .i_din   (w_din),
    .i_pop   (bus.RD_POP),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_ovf   (w_ovf),
    .o_unf   (w_unf)
  );

  assign bus.ALLOC_ACK = r_ack;
  assign bus.ALLOC_ADR = r_adr;
  assign bus.SCAFULL   = r_full;
  assign bus.NFREE     = r_nfree;
  assign bus.GTRGEMPTY = w_empty;
  assign bus.RADR      = w_head.adr;
  assign bus.L1ABIN    = w_head.l1abin;
  assign bus.MISSCNT   = r_miss;
  assign bus.ERR       = r_err;
endmodule

// File: tb/tb_sca_blk_sched.sv
// Directed plus randomized checks of sca_blk_sched against a queue-based model.
module tb_sca_blk_sched;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  sca_blk_sched_if bus ();
  sca_blk_sched dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 0 = free, 1 = allocated, 2 = queued
  int m_st [16];
  int m_qa [$];
  int m_ql [$];
  int m_ack, m_adr, m_miss, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_st[i] = 0;
    m_qa.delete();
    m_ql.delete();
    m_ack = 0; m_adr = 0; m_miss = 0; m_err = 0;
  endtask

  task automatic model_step(input bit req, input bit cv, input bit cd, input int ca,
                            input int cl, input bit pop, input bit rv, input int ra);
    int pre [16];
    bit popok, dopush;
    int g;
    pre = m_st;
    m_ack = 0;
    dopush = 0;
    if (req) begin
      g = -1;
      for (int i = 15; i >= 0; i--) if (pre[i] == 0) g = i;
      if (g >= 0) begin m_ack = 1; m_adr = g; m_st[g] = 1; end
      else if (m_miss < 255) m_miss++;
    end
    popok = pop && (m_qa.size() > 0);
    if (pop && !popok) m_err = 1;
    if (cv) begin
      if (pre[ca] != 1) m_err = 1;
      else if (cd) m_st[ca] = 0;
      else if (m_qa.size() == 16 && !popok) m_err = 1;
      else begin m_st[ca] = 2; dopush = 1; end
    end
    if (rv) begin
      if (pre[ra] == 2) m_st[ra] = 0;
      else m_err = 1;
    end
    if (popok) begin void'(m_qa.pop_front()); void'(m_ql.pop_front()); end
    if (dopush) begin m_qa.push_back(ca); m_ql.push_back(cl); end
  endtask

  task automatic check_all();
    int nf;
    nf = 0;
    for (int i = 0; i < 16; i++) if (m_st[i] == 0) nf++;
    chk("ack", bus.ALLOC_ACK, m_ack);
    if (m_ack) chk("alloc_adr", bus.ALLOC_ADR, m_adr);
    chk("nfree", bus.NFREE, nf);
    chk("scafull", bus.SCAFULL, (nf == 0));
    chk("gtrgempty", bus.GTRGEMPTY, (m_qa.size() == 0));
    chk("radr", bus.RADR, (m_qa.size() > 0) ? m_qa[0] : 0);
    chk("l1abin", bus.L1ABIN, (m_ql.size() > 0) ? m_ql[0] : 0);
    chk("misscnt", bus.MISSCNT, m_miss);
    chk("err", bus.ERR, m_err);
  endtask

  task automatic clr_in();
    bus.ALLOC_REQ = 0; bus.CONF_VLD = 0; bus.CONF_DROP = 0; bus.CONF_ADR = 0;
    bus.CONF_L1ABIN = 0; bus.RD_POP = 0; bus.RLS_VLD = 0; bus.RLS_ADR = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(bus.ALLOC_REQ, bus.CONF_VLD, bus.CONF_DROP, int'(bus.CONF_ADR),
               int'(bus.CONF_L1ABIN), bus.RD_POP, bus.RLS_VLD, int'(bus.RLS_ADR));
    #1;
    clr_in();
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clr_in();
    model_reset();
    @(posedge CLK); #1;
    check_all();
    RST = 1'b0;
  endtask

  task automatic alloc();
    bus.ALLOC_REQ = 1; tick();
  endtask

  task automatic conf(input int a, input int l1a, input bit drop);
    bus.CONF_VLD = 1; bus.CONF_DROP = drop; bus.CONF_ADR = 4'(a); bus.CONF_L1ABIN = 8'(l1a);
    tick();
  endtask

  task automatic pop();
    bus.RD_POP = 1; tick();
  endtask

  task automatic rls(input int a);
    bus.RLS_VLD = 1; bus.RLS_ADR = 4'(a); tick();
  endtask

  initial begin
    int alist [$];
    int qlist [$];
    clr_in();
    model_reset();
    #12;
    chk("rst_nfree", bus.NFREE, 16);
    chk("rst_scafull", bus.SCAFULL, 0);
    chk("rst_ack", bus.ALLOC_ACK, 0);
    chk("rst_adr", bus.ALLOC_ADR, 0);
    chk("rst_empty", bus.GTRGEMPTY, 1);
    chk("rst_radr", bus.RADR, 0);
    chk("rst_l1abin", bus.L1ABIN, 0);
    chk("rst_miss", bus.MISSCNT, 0);
    chk("rst_err", bus.ERR, 0);
    do_reset();

    // Three back-to-back allocations
    for (int i = 0; i < 3; i++) begin
      alloc();
      chk("t1_ack", bus.ALLOC_ACK, 1);
      chk("t1_adr", bus.ALLOC_ADR, i);
    end
    chk("t1_nfree", bus.NFREE, 13);

    // Confirm shows up at the head one cycle later
    do_reset();
    alloc();
    conf(0, 'h5A, 0);
    chk("t2_empty", bus.GTRGEMPTY, 0);
    chk("t2_radr", bus.RADR, 0);
    chk("t2_l1abin", bus.L1ABIN, 'h5A);
    pop();
    chk("t2_empty_after_pop", bus.GTRGEMPTY, 1);

    // Exhaust pool, saturate miss counter, release/grant ordering
    do_reset();
    for (int i = 0; i < 16; i++) alloc();
    for (int i = 0; i < 300; i++) alloc();
    chk("t3_scafull", bus.SCAFULL, 1);
    chk("t3_miss", bus.MISSCNT, 255);
    chk("t3_noack", bus.ALLOC_ACK, 0);
    conf(7, 'h11, 0);
    bus.RLS_VLD = 1; bus.RLS_ADR = 4'd7; bus.ALLOC_REQ = 1; tick();
    chk("t3_rls_noack", bus.ALLOC_ACK, 0);
    alloc();
    chk("t3_reack", bus.ALLOC_ACK, 1);
    chk("t3_readr", bus.ALLOC_ADR, 7);

    // Out-of-order confirms and a drop
    do_reset();
    for (int i = 0; i < 4; i++) alloc();
    conf(2, 'h22, 0);
    conf(0, 'h00, 0);
    conf(3, 'h33, 0);
    conf(1, 'h99, 1);
    chk("t4_nfree", bus.NFREE, 13);
    chk("t4_head0", bus.RADR, 2);
    pop();
    chk("t4_head1", bus.RADR, 0);
    pop();
    chk("t4_head2", bus.RADR, 3);
    chk("t4_l1a2", bus.L1ABIN, 'h33);

    // Protocol errors leave state alone
    do_reset();
    alloc();
    pop();
    chk("t5_err_pop", bus.ERR, 1);
    conf(9, 'h01, 0);
    rls(0);
    chk("t5_err_sticky", bus.ERR, 1);
    chk("t5_nfree", bus.NFREE, 15);

    // Simultaneous push/pop, then reset with a loaded queue
    do_reset();
    for (int i = 0; i < 3; i++) alloc();
    conf(0, 'hA0, 0);
    conf(1, 'hA1, 0);
    bus.RD_POP = 1; conf(2, 'hA2, 0);
    chk("t6_head", bus.RADR, 1);
    pop();
    chk("t6_head2", bus.RADR, 2);
    chk("t6_nonempty", bus.GTRGEMPTY, 0);
    pop();
    chk("t6_empty", bus.GTRGEMPTY, 1);
    for (int i = 0; i < 5; i++) alloc();
    for (int i = 0; i < 5; i++) conf(i, 'h40 + i, 0);
    RST = 1'b1;
    model_reset();
    #2;
    chk("t6_rst_empty", bus.GTRGEMPTY, 1);
    chk("t6_rst_nfree", bus.NFREE, 16);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Randomized traffic, biased toward legal operations
    do_reset();
    for (int n = 0; n < 600; n++) begin
      alist.delete();
      qlist.delete();
      for (int i = 0; i < 16; i++) begin
        if (m_st[i] == 1) alist.push_back(i);
        if (m_st[i] == 2) qlist.push_back(i);
      end
      bus.ALLOC_REQ = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        bus.CONF_VLD    = 1;
        bus.CONF_DROP   = ($urandom_range(0, 3) == 0);
        bus.CONF_L1ABIN = 8'($urandom_range(0, 255));
        if (alist.size() > 0 && $urandom_range(0, 7) != 0)
          bus.CONF_ADR = 4'(alist[$urandom_range(0, alist.size() - 1)]);
        else
          bus.CONF_ADR = 4'($urandom_range(0, 15));
      end
      bus.RD_POP = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.RLS_VLD = 1;
        if (qlist.size() > 0 && $urandom_range(0, 7) != 0)
          bus.RLS_ADR = 4'(qlist[$urandom_range(0, qlist.size() - 1)]);
        else
          bus.RLS_ADR = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
